mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter: state encoding and
// default geometry.
package mem_arb_pkg;

    localparam int DEF_AW           = 32;
    localparam int DEF_DW           = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IBUSY = 3'd1,
        DBUSY = 3'd2,
        IRESP = 3'd3,
        DRESP = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one single-port memory,
// with data priority bounded by a starvation counter for the fetch side.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [3:0]    d_wmask,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_wmask,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    arb_state_t    state, next;
    logic [CW-1:0] dcnt;
    logic          d_grant, i_grant;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_we;
    logic [3:0]    lat_wmask;

    always_ff @(posedge clk) begin
        if (rstn) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next      = state;
        d_grant   = 1'b0;
        i_grant   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wmask = '0;
        if_ready  = 1'b0;
        d_ready   = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless the fetch side has waited out its allowance.
                if (d_req && (!if_req || dcnt < LIM)) begin
                    d_grant = 1'b1;
                    next    = DBUSY;
                end else if (if_req) begin
                    i_grant = 1'b1;
                    next    = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                mem_req   = 1'b1;
                mem_we    = lat_we;
                mem_wmask = lat_wmask;
                if (mem_ack) next = (state == IBUSY) ? IRESP : DRESP;
            end
            IRESP: begin
                if_ready = 1'b1;
                next     = IDLE;
            end
            DRESP: begin
                d_ready = 1'b1;
                next    = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge clk) begin
        if (rstn) begin
            dcnt      <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_wmask <= '0;
        end else begin
            if (d_grant) begin
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
                lat_we    <= d_we;
                lat_wmask <= d_wmask;
                if (!if_req)          dcnt <= '0;
                else if (dcnt != LIM) dcnt <= dcnt + CW'(1);
            end else if (i_grant) begin
                lat_addr  <= if_addr;
                lat_wdata <= '0;
                lat_we    <= 1'b0;
                lat_wmask <= '0;
                dcnt      <= '0;
            end
            if (state == IBUSY && mem_ack) if_rdata <= mem_rdata;
            if (state == DBUSY && mem_ack) d_rdata  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-built
// sequences for starvation, back-to-back contention and mid-transaction reset.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] IA    = 32'h0000_0010;
    localparam logic [31:0] DA    = 32'h0C00_0048;
    localparam logic [31:0] WD    = 32'hDEAD_BEEF;
    localparam logic [31:0] FETCH = 32'h0040_0093;
    localparam logic [31:0] DRD   = 32'hCAFE_F00D;
    localparam logic [31:0] SRD   = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          if_req, if_ready;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ready;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [3:0]    d_wmask;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          rst, ir, dr, we, ack;
        logic [31:0] rd;
        bit          e_mreq, e_mwe, e_ir, e_dr;
        logic [31:0] e_addr, e_ird, e_drd;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, compare mid-cycle, advance past the next edge.
    task automatic apply(input vec_t v, input string tag);
        rstn = v.rst; if_req = v.ir; d_req = v.dr; d_we = v.we;
        mem_ack = v.ack; mem_rdata = v.rd;
        @(negedge clk);
        chk({tag, ".mem_req"},  {31'd0, mem_req},  {31'd0, v.e_mreq});
        chk({tag, ".mem_we"},   {31'd0, mem_we},   {31'd0, v.e_mwe});
        chk({tag, ".if_ready"}, {31'd0, if_ready}, {31'd0, v.e_ir});
        chk({tag, ".d_ready"},  {31'd0, d_ready},  {31'd0, v.e_dr});
        chk({tag, ".if_rdata"}, if_rdata, v.e_ird);
        chk({tag, ".d_rdata"},  d_rdata,  v.e_drd);
        if (v.e_mreq) chk({tag, ".mem_addr"}, mem_addr, v.e_addr);
        if (!v.e_mreq || v.e_addr == IA)
            chk({tag, ".mem_wmask"}, {28'd0, mem_wmask}, 32'd0);
        if (v.e_mreq && v.e_mwe) begin
            chk({tag, ".mem_wdata"}, mem_wdata, WD);
            chk({tag, ".mem_wmask"}, {28'd0, mem_wmask}, 32'hF);
        end
        @(posedge clk); #1;
    endtask

    vec_t        tbl[13];
    vec_t        seq[14];
    bit          got[10];
    logic [9:0]  exp_pat;
    int unsigned ngr;
    bit          done;

    initial begin
        if_addr = IA; d_addr = DA; d_wdata = WD; d_wmask = 4'hF;
        rstn = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        @(posedge clk); #1;

        //          rst ir dr we ack rd                 mreq mwe ir dr addr  ird    drd
        tbl[0]  = '{1, 1, 1, 0, 0, 32'h0,             0, 0, 0, 0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{1, 1, 1, 0, 0, 32'h0,             0, 0, 0, 0, 32'h0, 32'h0, 32'h0};
        tbl[2]  = '{0, 1, 0, 0, 1, FETCH,             0, 0, 0, 0, 32'h0, 32'h0, 32'h0};
        tbl[3]  = '{0, 1, 0, 0, 1, FETCH,             1, 0, 0, 0, IA,    32'h0, 32'h0};
        tbl[4]  = '{0, 1, 0, 0, 1, FETCH,             0, 0, 1, 0, 32'h0, FETCH, 32'h0};
        tbl[5]  = '{0, 0, 0, 0, 1, 32'h1111_1111,     0, 0, 0, 0, 32'h0, FETCH, 32'h0};
        tbl[6]  = '{0, 0, 1, 1, 0, 32'h2222_2222,     0, 0, 0, 0, 32'h0, FETCH, 32'h0};
        tbl[7]  = '{0, 0, 1, 1, 0, 32'h2222_2222,     1, 1, 0, 0, DA,    FETCH, 32'h0};
        tbl[8]  = '{0, 0, 1, 1, 0, 32'h2222_2222,     1, 1, 0, 0, DA,    FETCH, 32'h0};
        tbl[9]  = '{0, 0, 1, 1, 0, 32'h2222_2222,     1, 1, 0, 0, DA,    FETCH, 32'h0};
        tbl[10] = '{0, 0, 1, 1, 1, DRD,               1, 1, 0, 0, DA,    FETCH, 32'h0};
        tbl[11] = '{0, 0, 1, 1, 0, 32'h0,             0, 0, 0, 1, 32'h0, FETCH, DRD};
        tbl[12] = '{0, 0, 0, 0, 0, 32'h0,             0, 0, 0, 0, 32'h0, FETCH, DRD};

        for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Both ports requesting continuously: four data grants, then one fetch.
        exp_pat = 10'b1111011110;
        rstn = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        mem_ack = 1'b1; mem_rdata = SRD;
        ngr = 0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (mem_req && ngr < 10) begin
                got[ngr] = (mem_addr == DA);
                ngr++;
            end
            if (ngr == 10 && if_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("starve.ngrants", ngr, 32'd10);
        chk("starve.done", {31'd0, done}, 32'd1);
        for (int k = 0; k < 10; k++)
            chk($sformatf("starve.grant%0d", k), {31'd0, got[k]}, {31'd0, exp_pat[9-k]});

        // Data request arrives during a fetch; with dcnt clear it wins next.
        seq[0]  = '{0, 1, 0, 0, 1, 32'h1234_5678,     0, 0, 0, 0, 32'h0, SRD,          SRD};
        seq[1]  = '{0, 1, 1, 0, 1, 32'h1234_5678,     1, 0, 0, 0, IA,    SRD,          SRD};
        seq[2]  = '{0, 1, 1, 0, 1, 32'h9999_0000,     0, 0, 1, 0, 32'h0, 32'h1234_5678, SRD};
        seq[3]  = '{0, 1, 1, 0, 1, 32'h9999_0000,     0, 0, 0, 0, 32'h0, 32'h1234_5678, SRD};
        seq[4]  = '{0, 1, 1, 0, 1, 32'h9999_0000,     1, 0, 0, 0, DA,    32'h1234_5678, SRD};
        seq[5]  = '{0, 1, 1, 0, 1, 32'h0000_0077,     0, 0, 0, 1, 32'h0, 32'h1234_5678, 32'h9999_0000};
        seq[6]  = '{0, 1, 0, 0, 1, 32'h0000_0077,     0, 0, 0, 0, 32'h0, 32'h1234_5678, 32'h9999_0000};
        seq[7]  = '{0, 1, 0, 0, 1, 32'h0000_0077,     1, 0, 0, 0, IA,    32'h1234_5678, 32'h9999_0000};
        seq[8]  = '{0, 1, 0, 0, 0, 32'h0,             0, 0, 1, 0, 32'h0, 32'h0000_0077, 32'h9999_0000};
        seq[9]  = '{0, 0, 0, 0, 0, 32'h0,             0, 0, 0, 0, 32'h0, 32'h0000_0077, 32'h9999_0000};
        // Reset lands in DBUSY together with mem_ack: no ready, rdata cleared.
        seq[10] = '{0, 0, 1, 0, 0, 32'h0,             0, 0, 0, 0, 32'h0, 32'h0000_0077, 32'h9999_0000};
        seq[11] = '{1, 0, 1, 0, 1, 32'h5555_5555,     1, 0, 0, 0, DA,    32'h0000_0077, 32'h9999_0000};
        seq[12] = '{0, 0, 0, 0, 0, 32'h0,             0, 0, 0, 0, 32'h0, 32'h0,         32'h0};
        seq[13] = '{0, 0, 0, 0, 0, 32'h0,             0, 0, 0, 0, 32'h0, 32'h0,         32'h0};

        for (int i = 0; i < 14; i++) apply(seq[i], $sformatf("seq%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
